mem_access_ctrl: RTL and testbench

// Sequences every load/store in the MEM stage onto a single-port data-memory bus.

---
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Single-port data-memory bus between the MEM-stage access controller (master)
// and the data memory (slave).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: issues one bus access per memory instruction,
// returns right-aligned load data and stalls the pipeline until the result is ready.
module mem_access_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              pipe_advance_i,
  input  logic              flush_i,
  mem_access_ctrl_if.master bus,
  output logic              dcache_data_valid_o,
  output logic [DATA_W-1:0] dcache_data_o,
  output logic              misalign_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {IDLE, REQ, WAIT_R, DRAIN, DONE} state_e;

  state_e            state_r, state_s;
  logic              valid_s, misalign_s, issue_s, capture_s;
  logic              is_load_s, is_store_s, is_mem_s, misaligned_s;
  logic [2:0]        lane_s, lane_r;
  logic              req_r, we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, data_r;
  logic [7:0]        wstrb_r;
  logic              unused_s;

  function automatic logic [7:0] size_strobe(input logic [1:0] size);
    logic [7:0] strb;
    case (size)
      2'd0:    strb = 8'h01;
      2'd1:    strb = 8'h03;
      2'd2:    strb = 8'h0F;
      2'd3:    strb = 8'hFF;
      default: strb = 8'h00;
    endcase
    return strb;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lane);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = lane[0];
      2'd2:    mis = |lane[1:0];
      2'd3:    mis = |lane;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // funct3[2] selects sign/zero extension, which happens downstream.
  assign unused_s     = funct3_i[2];
  assign lane_s       = addr_i[2:0];
  assign is_load_s    = (opcode_i == OP_LOAD);
  assign is_store_s   = (opcode_i == OP_STORE);
  assign is_mem_s     = req_valid_i & (is_load_s | is_store_s);
  assign misaligned_s = is_misaligned(funct3_i[1:0], lane_s);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state selection and the combinational MEM-stage handshake.
  always_comb begin
    state_s    = state_r;
    valid_s    = 1'b0;
    misalign_s = 1'b0;
    issue_s    = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mem_s) begin
          if (misaligned_s) begin
            misalign_s = 1'b1;
            valid_s    = 1'b1;
          end else if (flush_i) begin
            valid_s = 1'b1;
          end else begin
            issue_s = 1'b1;
            state_s = REQ;
          end
        end else begin
          valid_s = 1'b1;
        end
      end
      REQ: begin
        // A granted load still owes a response, so a flush must drain it.
        if (flush_i) begin
          state_s = (bus.mem_gnt && !we_r) ? DRAIN : IDLE;
        end else if (bus.mem_gnt) begin
          state_s = we_r ? DONE : WAIT_R;
        end else begin
          state_s = REQ;
        end
      end
      WAIT_R: begin
        if (bus.mem_rvalid) begin
          capture_s = !flush_i;
          state_s   = flush_i ? IDLE : DONE;
        end else if (flush_i) begin
          state_s = DRAIN;
        end else begin
          state_s = WAIT_R;
        end
      end
      DRAIN: begin
        if (bus.mem_rvalid) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        valid_s = 1'b1;
        if (pipe_advance_i || flush_i) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bus fields are captured at issue and held stable for the whole request phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      wstrb_r <= 8'h00;
      lane_r  <= 3'd0;
    end else if (issue_s) begin
      req_r   <= 1'b1;
      we_r    <= is_store_s;
      addr_r  <= {addr_i[ADDR_W-1:3], 3'b000};
      wdata_r <= store_data_i << {lane_s, 3'b000};
      wstrb_r <= size_strobe(funct3_i[1:0]) << lane_s;
      lane_r  <= lane_s;
    end else if (req_r && (state_s != REQ)) begin
      req_r   <= 1'b0;
      wstrb_r <= 8'h00;
    end
  end

  // Load result register; cleared whenever the controller returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      data_r <= bus.mem_rdata >> {lane_r, 3'b000};
    end else if (state_s == IDLE) begin
      data_r <= {DATA_W{1'b0}};
    end
  end

  assign bus.mem_req          = req_r;
  assign bus.mem_we           = we_r;
  assign bus.mem_addr         = addr_r;
  assign bus.mem_wdata        = wdata_r;
  assign bus.mem_wstrb        = wstrb_r;
  assign dcache_data_o        = data_r;
  assign dcache_data_valid_o  = valid_s;
  assign misalign_o           = misalign_s;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: the bench plays pipeline and memory and
// predicts every output from transaction-level timing and byte-lane arithmetic.
module tb_mem_access_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i;
  logic [63:0] store_data_i;
  logic        pipe_advance_i;
  logic        flush_i;
  logic        dcache_data_valid_o;
  logic [63:0] dcache_data_o;
  logic        misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid_i         (req_valid_i),
    .opcode_i            (opcode_i),
    .funct3_i            (funct3_i),
    .addr_i              (addr_i),
    .store_data_i        (store_data_i),
    .pipe_advance_i      (pipe_advance_i),
    .flush_i             (flush_i),
    .bus                 (bus),
    .dcache_data_valid_o (dcache_data_valid_o),
    .dcache_data_o       (dcache_data_o),
    .misalign_o          (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
    end
  endtask

  // kind: 0 non-memory, 1 load, 2 store. flush_at < 0 means no flush.
  task automatic run_txn(input int kind, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [63:0] rdata,
                         input int gnt_dly, input int r_dly, input int bp, input int flush_at);
    int          nbytes, lane, gnt_cyc, r_cyc, done_cyc, end_cyc, idle_cyc;
    bit          is_store, mis, granted, exp_req, exp_valid;
    logic [6:0]  op;
    logic [7:0]  exp_strb;
    logic [63:0] exp_addr, exp_wdata, exp_load, junk;
    nbytes   = 1 << size;
    lane     = int'(addr % 64'd8);
    is_store = (kind == 2);
    mis      = (kind != 0) && ((addr % nbytes) != 64'd0);
    if (kind == 1) begin
      op = OP_LOAD;
    end else if (kind == 2) begin
      op = OP_STORE;
    end else begin
      op = 7'($urandom);
      if (op == OP_LOAD || op == OP_STORE) op = 7'b0110011;
    end

    if (kind == 0 || mis) begin
      req_valid_i = (kind == 0) ? 1'($urandom) : 1'b1;
      if (kind == 0 && !req_valid_i) op = OP_LOAD;
      opcode_i = op; funct3_i = {1'($urandom), size}; addr_i = addr; store_data_i = sdata;
      pipe_advance_i = 1'b1; flush_i = 1'b0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      #1;
      check_eq("imm_valid", dcache_data_valid_o, 1'b1);
      check_eq("imm_misalign", misalign_o, mis);
      check_eq("imm_req", bus.mem_req, 1'b0);
      if (mis) check_eq("mis_data", dcache_data_o, 64'd0);
      @(negedge clk);
      return;
    end

    exp_addr = addr - (addr % 64'd8);
    exp_strb = 8'h00; exp_wdata = 64'd0; exp_load = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (lane + i < 8) begin
        if (i < nbytes) exp_strb[lane+i] = 1'b1;
        exp_wdata[8*(lane+i) +: 8] = sdata[8*i +: 8];
        exp_load[8*i +: 8]         = rdata[8*(lane+i) +: 8];
      end
    end
    gnt_cyc  = 1 + gnt_dly;
    r_cyc    = gnt_cyc + r_dly;
    done_cyc = is_store ? gnt_cyc + 1 : r_cyc + 1;
    granted  = (flush_at < 0) || (flush_at >= gnt_cyc);
    end_cyc  = (flush_at >= 0) ? flush_at : done_cyc + bp;

    for (int cyc = 0; cyc <= end_cyc; cyc++) begin
      req_valid_i = 1'b1; opcode_i = op; funct3_i = {1'b0, size};
      addr_i = addr; store_data_i = sdata;
      flush_i        = (cyc == flush_at);
      pipe_advance_i = (flush_at < 0) && (cyc == end_cyc);
      bus.mem_gnt    = granted && (cyc == gnt_cyc);
      bus.mem_rvalid = !is_store && granted && (cyc == r_cyc);
      junk           = {$urandom, $urandom};
      bus.mem_rdata  = (cyc == r_cyc) ? rdata : junk;
      #1;
      exp_req   = (cyc >= 1) && (cyc <= gnt_cyc) && (flush_at < 0 || cyc <= flush_at);
      exp_valid = (flush_at < 0) && (cyc >= done_cyc);
      check_eq("req", bus.mem_req, exp_req);
      check_eq("wstrb", bus.mem_wstrb, exp_req ? exp_strb : 8'h00);
      if (exp_req) begin
        check_eq("addr", bus.mem_addr, exp_addr);
        check_eq("we", bus.mem_we, is_store);
        if (is_store) check_eq("wdata", bus.mem_wdata, exp_wdata);
      end
      check_eq("valid", dcache_data_valid_o, exp_valid);
      check_eq("misalign", misalign_o, 1'b0);
      if (exp_valid && !is_store) check_eq("ld_data", dcache_data_o, exp_load);
      @(negedge clk);
    end

    // An outstanding load response must be absorbed before anything new is issued.
    if (flush_at >= 0) begin
      idle_cyc = (!is_store && flush_at >= gnt_cyc && flush_at < r_cyc) ? r_cyc + 1 : flush_at + 1;
      for (int cyc = flush_at + 1; cyc < idle_cyc; cyc++) begin
        junk = {$urandom, $urandom};
        req_valid_i = 1'b1; opcode_i = OP_LOAD; funct3_i = 3'b011;
        addr_i = junk & ~64'h7; flush_i = 1'b0; pipe_advance_i = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = (cyc == r_cyc); bus.mem_rdata = rdata;
        #1;
        check_eq("drain_req", bus.mem_req, 1'b0);
        check_eq("drain_valid", dcache_data_valid_o, 1'b0);
        @(negedge clk);
      end
    end
  endtask

  // Reset strikes in the third cycle of an aligned load, then a stray response arrives.
  task automatic reset_mid(input int gnt_dly, input logic [63:0] rdata);
    for (int cyc = 0; cyc <= 2; cyc++) begin
      req_valid_i = 1'b1; opcode_i = OP_LOAD; funct3_i = 3'b011; addr_i = 64'h4000;
      flush_i = 1'b0; pipe_advance_i = 1'b0;
      bus.mem_gnt = (cyc == 1 + gnt_dly); bus.mem_rvalid = 1'b0; bus.mem_rdata = rdata;
      if (cyc < 2) @(negedge clk);
    end
    #1;
    check_eq("pre_rst_req", bus.mem_req, gnt_dly > 0);
    rst = 1'b1;
    #1;
    check_eq("rst_req", bus.mem_req, 1'b0);
    check_eq("rst_wstrb", bus.mem_wstrb, 8'h00);
    check_eq("rst_data", dcache_data_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; req_valid_i = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
    #1;
    check_eq("stray_valid", dcache_data_valid_o, 1'b1);
    check_eq("stray_req", bus.mem_req, 1'b0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    #1;
    check_eq("stray_data", dcache_data_o, 64'd0);
    check_eq("stray_valid2", dcache_data_valid_o, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int          kind, g, r, bp, f;
    logic [1:0]  sz;
    logic [63:0] a;
    rst = 1'b1;
    req_valid_i = 1'b0; opcode_i = 7'd0; funct3_i = 3'd0; addr_i = 64'd0; store_data_i = 64'd0;
    pipe_advance_i = 1'b0; flush_i = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_req", bus.mem_req, 1'b0);
    check_eq("reset_wstrb", bus.mem_wstrb, 8'h00);
    check_eq("reset_we", bus.mem_we, 1'b0);
    check_eq("reset_addr", bus.mem_addr, 64'd0);
    check_eq("reset_data", dcache_data_o, 64'd0);
    check_eq("reset_misalign", misalign_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(1, 2'd0, 64'h1003, 64'd0, 64'h8877665544332211, 0, 1, 0, -1);
    run_txn(2, 2'd1, 64'h2006, 64'hBEEF, 64'd0, 3, 1, 0, -1);
    run_txn(1, 2'd2, 64'h3002, 64'd0, 64'd0, 0, 1, 0, -1);
    run_txn(1, 2'd3, 64'h5008, 64'd0, 64'h0123456789ABCDEF, 0, 2, 0, 1);
    run_txn(1, 2'd3, 64'h6000, 64'd0, 64'hFEDCBA9876543210, 0, 1, 0, -1);
    run_txn(1, 2'd2, 64'h7004, 64'd0, 64'hCAFEF00DDEADBEEF, 0, 1, 4, -1);
    run_txn(2, 2'd3, 64'h8000, 64'h1122334455667788, 64'd0, 2, 1, 0, 1);
    run_txn(0, 2'd0, 64'h9000, 64'd0, 64'd0, 0, 1, 0, -1);
    reset_mid(3, 64'h5555AAAA5555AAAA);
    reset_mid(0, 64'hA5A5A5A5A5A5A5A5);

    for (int t = 0; t < 300; t++) begin
      kind = int'($urandom_range(0, 4));
      kind = (kind >= 3) ? 2 : ((kind >= 1) ? 1 : 0);
      sz   = 2'($urandom);
      a    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      g  = int'($urandom_range(0, 3));
      r  = int'($urandom_range(1, 3));
      bp = int'($urandom_range(0, 3));
      f  = -1;
      if ($urandom_range(0, 3) == 0) f = int'($urandom_range(1, (kind == 2) ? 1 + g : 1 + g + r));
      run_txn(kind, sz, a, {$urandom, $urandom}, {$urandom, $urandom}, g, r, bp, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
